// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// default reset PC and bus response codes.
package ysyx_25030093_ifu_pkg;

  localparam int unsigned IFU_ADDR_W   = 32;
  localparam int unsigned IFU_INST_W   = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

  // Fetch sequence: request address, collect data, present to decode,
  // then wait for write-back to retire and supply the next PC.
  typedef enum logic [1:0] {
    S_ADDR    = 2'd0,
    S_DATA    = 2'd1,
    S_HOLD    = 2'd2,
    S_WAIT_WB = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25030093_ifu_pcreg.sv
// Architectural PC register with word-alignment check.
module ysyx_25030093_ifu_pcreg
  import ysyx_25030093_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] dnpc,
  output logic [ADDR_W-1:0] pc,
  output logic              misaligned
);

  // PC updates only on reset or on a retirement handshake; wrap is plain truncation.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= dnpc;
    end
  end

  assign misaligned = |pc[1:0];

endmodule

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: holds the PC, issues one read per instruction on
// a valid/ready bus, presents {pc, inst, fetch_err} to decode, and waits for
// write-back to retire before fetching the next PC.
module ysyx_25030093_ifu
  import ysyx_25030093_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  // write-back retirement handshake
  input  logic                  wbu_valid,
  input  logic [ADDR_W-1:0]     wbu_dnpc,
  output logic                  wbu_ready,
  // memory read bus
  output logic                  mem_arvalid,
  output logic [ADDR_W-1:0]     mem_araddr,
  input  logic                  mem_arready,
  input  logic                  mem_rvalid,
  input  logic [IFU_INST_W-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  output logic                  mem_rready,
  // decode handoff
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [ADDR_W-1:0]     pc,
  output logic [IFU_INST_W-1:0] inst,
  output logic                  fetch_err
);

  ifu_state_e state_q;
  logic       misaligned;
  logic       pc_load;

  // A retirement is only consumed while waiting for write-back.
  assign pc_load = (state_q == S_WAIT_WB) && wbu_valid;

  ysyx_25030093_ifu_pcreg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pcreg (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .dnpc       (wbu_dnpc),
    .pc         (pc),
    .misaligned (misaligned)
  );

  // Fetch FSM plus the instruction/error registers it loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ADDR;
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          // A misaligned PC never reaches the bus; it is reported as a fault.
          if (misaligned) begin
            inst      <= '0;
            fetch_err <= 1'b1;
            state_q   <= S_HOLD;
          end else if (mem_arready) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (mem_rvalid) begin
            inst      <= mem_rdata;
            fetch_err <= (mem_rresp != RESP_OKAY);
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (in_ready) begin
            state_q <= S_WAIT_WB;
          end
        end
        S_WAIT_WB: begin
          if (wbu_valid) begin
            fetch_err <= 1'b0;
            state_q   <= S_ADDR;
          end
        end
        default: state_q <= S_ADDR;
      endcase
    end
  end

  // Handshake outputs decode directly from the registered state, so reset
  // takes effect on them immediately.
  assign mem_arvalid = (state_q == S_ADDR) && !misaligned;
  assign mem_araddr  = pc;
  assign mem_rready  = (state_q == S_DATA);
  assign out_valid   = (state_q == S_HOLD);
  assign wbu_ready   = (state_q == S_WAIT_WB);

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed testbench for the instruction fetch unit. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_ysyx_25030093_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbu_valid;
  logic [31:0] wbu_dnpc;
  logic        wbu_ready;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;
  int ar_hs = 0;

  ysyx_25030093_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .wbu_valid   (wbu_valid),
    .wbu_dnpc    (wbu_dnpc),
    .wbu_ready   (wbu_ready),
    .mem_arvalid (mem_arvalid),
    .mem_araddr  (mem_araddr),
    .mem_arready (mem_arready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rready  (mem_rready),
    .out_valid   (out_valid),
    .in_ready    (in_ready),
    .pc          (pc),
    .inst        (inst),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Count accepted read requests; flag any response that arrives with an acceptance.
  always @(posedge clk) begin
    if (!rst && mem_arvalid && mem_arready) ar_hs++;
    if (!rst && mem_arready && mem_rvalid) begin
      bad++;
      $display("FAIL protocol: arready and rvalid both high at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Zero-wait memory: accept now, respond on the next cycle.
  task automatic fetch_zero_wait(input logic [31:0] data, input logic [1:0] resp);
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = data;
    mem_rresp   = resp;
    tick();
    mem_rvalid  = 1'b0;
    mem_rresp   = 2'b00;
  endtask

  // From HOLD: decode accepts, then write-back retires with the given next PC.
  task automatic handoff(input logic [31:0] dnpc);
    in_ready = 1'b1;
    tick();
    in_ready  = 1'b0;
    wbu_valid = 1'b1;
    wbu_dnpc  = dnpc;
    tick();
    wbu_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({mem_arvalid, mem_araddr, out_valid, mem_rready, wbu_ready, pc, inst, fetch_err} !==
        {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: arv=%b addr=%h ov=%b rr=%b wr=%b pc=%h inst=%h err=%b",
               mem_arvalid, mem_araddr, out_valid, mem_rready, wbu_ready, pc, inst, fetch_err);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h8000_0000}) begin
      bad++;
      $display("FAIL first_addr: arv=%b addr=%h want 1 80000000", mem_arvalid, mem_araddr);
    end
  endtask

  task automatic test_zero_wait();
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    total++;
    if ({mem_arvalid, mem_rready, out_valid} !== 3'b010) begin
      bad++;
      $display("FAIL zw_data_phase: arv=%b rr=%b ov=%b want 0 1 0", mem_arvalid, mem_rready, out_valid);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0413;
    mem_rresp  = 2'b00;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({out_valid, pc, inst, fetch_err} !== {1'b1, 32'h8000_0000, 32'h0000_0413, 1'b0}) begin
      bad++;
      $display("FAIL zw_present: ov=%b pc=%h inst=%h err=%b want 1 80000000 00000413 0",
               out_valid, pc, inst, fetch_err);
    end
    handoff(32'h8000_0004);
    total++;
    if ({mem_arvalid, mem_araddr, wbu_ready} !== {1'b1, 32'h8000_0004, 1'b0}) begin
      bad++;
      $display("FAIL zw_next_addr: arv=%b addr=%h wr=%b want 1 80000004 0", mem_arvalid, mem_araddr, wbu_ready);
    end
  endtask

  task automatic test_delayed_mem();
    int hs0;
    int errs;
    hs0  = ar_hs;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h8000_0004}) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL dly_addr_stable: %0d unstable cycles, want 0", errs);
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    errs = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({mem_rready, out_valid, inst} !== {1'b1, 1'b0, 32'h0000_0413}) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL dly_wait_data: %0d bad cycles, want 0 (rr=%b ov=%b inst=%h)", errs, mem_rready, out_valid, inst);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0010_0073;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({out_valid, pc, inst, fetch_err} !== {1'b1, 32'h8000_0004, 32'h0010_0073, 1'b0}) begin
      bad++;
      $display("FAIL dly_present: ov=%b pc=%h inst=%h err=%b want 1 80000004 00100073 0",
               out_valid, pc, inst, fetch_err);
    end
    total++;
    if (ar_hs - hs0 != 1) begin
      bad++;
      $display("FAIL dly_single_req: got %0d requests, want 1", ar_hs - hs0);
    end
  endtask

  task automatic test_decode_stall();
    int errs;
    errs = 0;
    in_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({out_valid, pc, inst, wbu_ready} !== {1'b1, 32'h8000_0004, 32'h0010_0073, 1'b0}) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_stable: %0d bad cycles, want 0", errs);
    end
  endtask

  task automatic test_wbu_handshake();
    wbu_valid = 1'b1;
    wbu_dnpc  = 32'h1234_5678;
    tick();
    wbu_valid = 1'b0;
    total++;
    if ({out_valid, pc, wbu_ready} !== {1'b1, 32'h8000_0004, 1'b0}) begin
      bad++;
      $display("FAIL wbu_ignored_in_hold: ov=%b pc=%h wr=%b want 1 80000004 0", out_valid, pc, wbu_ready);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    total++;
    if ({wbu_ready, out_valid, mem_arvalid} !== 3'b100) begin
      bad++;
      $display("FAIL wbu_wait: wr=%b ov=%b arv=%b want 1 0 0", wbu_ready, out_valid, mem_arvalid);
    end
    wbu_valid = 1'b1;
    wbu_dnpc  = 32'h8000_0010;
    tick();
    wbu_valid = 1'b0;
    total++;
    if ({mem_arvalid, mem_araddr, pc, wbu_ready} !== {1'b1, 32'h8000_0010, 32'h8000_0010, 1'b0}) begin
      bad++;
      $display("FAIL wbu_next_addr: arv=%b addr=%h pc=%h wr=%b want 1 80000010 80000010 0",
               mem_arvalid, mem_araddr, pc, wbu_ready);
    end
  endtask

  task automatic test_misaligned();
    int hs0;
    fetch_zero_wait(32'h0000_0013, 2'b00);
    handoff(32'h8000_0006);
    hs0 = ar_hs;
    total++;
    if (mem_arvalid !== 1'b0) begin
      bad++;
      $display("FAIL mis_no_request: arv=%b want 0", mem_arvalid);
    end
    // Offer acceptance anyway; the misaligned fetch must not use it.
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    total++;
    if ({out_valid, pc, inst, fetch_err, mem_rready} !== {1'b1, 32'h8000_0006, 32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mis_fault: ov=%b pc=%h inst=%h err=%b rr=%b want 1 80000006 00000000 1 0",
               out_valid, pc, inst, fetch_err, mem_rready);
    end
    total++;
    if (ar_hs != hs0) begin
      bad++;
      $display("FAIL mis_req_count: got %0d requests, want 0", ar_hs - hs0);
    end
    handoff(32'h8000_0008);
    total++;
    if ({mem_arvalid, mem_araddr, fetch_err} !== {1'b1, 32'h8000_0008, 1'b0}) begin
      bad++;
      $display("FAIL mis_recover_addr: arv=%b addr=%h err=%b want 1 80000008 0", mem_arvalid, mem_araddr, fetch_err);
    end
    fetch_zero_wait(32'h00a0_0513, 2'b00);
    total++;
    if ({out_valid, pc, inst, fetch_err} !== {1'b1, 32'h8000_0008, 32'h00a0_0513, 1'b0}) begin
      bad++;
      $display("FAIL mis_recover: ov=%b pc=%h inst=%h err=%b want 1 80000008 00a00513 0",
               out_valid, pc, inst, fetch_err);
    end
  endtask

  task automatic test_bus_error();
    handoff(32'h8000_000c);
    fetch_zero_wait(32'hdead_beef, 2'b10);
    total++;
    if ({out_valid, pc, inst, fetch_err} !== {1'b1, 32'h8000_000c, 32'hdead_beef, 1'b1}) begin
      bad++;
      $display("FAIL rresp_err: ov=%b pc=%h inst=%h err=%b want 1 8000000c deadbeef 1",
               out_valid, pc, inst, fetch_err);
    end
  endtask

  task automatic test_reset_mid();
    handoff(32'h8000_0020);
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    total++;
    if (mem_rready !== 1'b1) begin
      bad++;
      $display("FAIL mid_in_data: rr=%b want 1", mem_rready);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_arvalid, mem_araddr, mem_rready, out_valid, wbu_ready, pc, inst, fetch_err} !==
        {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_async_reset: arv=%b addr=%h rr=%b ov=%b wr=%b pc=%h inst=%h err=%b",
               mem_arvalid, mem_araddr, mem_rready, out_valid, wbu_ready, pc, inst, fetch_err);
    end
    @(negedge clk);
    rst = 1'b0;
    // A stray response outside DATA must not be consumed.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hffff_ffff;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({mem_arvalid, mem_araddr, out_valid, inst} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL stray_rvalid: arv=%b addr=%h ov=%b inst=%h want 1 80000000 0 00000000",
               mem_arvalid, mem_araddr, out_valid, inst);
    end
    fetch_zero_wait(32'h0000_0297, 2'b00);
    total++;
    if ({out_valid, pc, inst, fetch_err} !== {1'b1, 32'h8000_0000, 32'h0000_0297, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_fetch: ov=%b pc=%h inst=%h err=%b want 1 80000000 00000297 0",
               out_valid, pc, inst, fetch_err);
    end
  endtask

  initial begin
    rst         = 1'b1;
    wbu_valid   = 1'b0;
    wbu_dnpc    = '0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = 2'b00;
    in_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_delayed_mem();
    test_decode_stall();
    test_wbu_handshake();
    test_misaligned();
    test_bus_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
